// File: rtl/sonar_pkg.sv
// Shared sonar definitions: time-of-flight FSM states, default counter width
// and the no-echo code.
package sonar_pkg;

  localparam int TOF_CNT_W = 24;
  localparam logic [TOF_CNT_W-1:0] TOF_NO_ECHO = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_LISTEN,
    ST_DONE
  } tof_state_t;

endpackage

// File: rtl/echo_debounce.sv
// Echo qualifier: counts consecutive high comparator samples and flags an echo
// once the run reaches the debounce length, reporting where the run began.
module echo_debounce
  import sonar_pkg::*;
#(
  parameter int CNT_W = TOF_CNT_W,
  parameter int DEB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample,
  input  logic             cmp_in,
  input  logic [CNT_W-1:0] index,
  input  logic [DEB_W-1:0] deb_len,
  output logic             echo,
  output logic [CNT_W-1:0] echo_tof
);

  logic [DEB_W-1:0] run;
  logic [DEB_W-1:0] deb_eff;
  logic [DEB_W:0]   run_inc;
  logic [CNT_W-1:0] run_start;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    deb_eff  = (deb_len == '0) ? DEB_W'(1) : deb_len;
    run_inc  = {1'b0, run} + (DEB_W+1)'(1);
    echo     = sample && cmp_in && (run_inc >= {1'b0, deb_eff});
    // A run that begins on this very sample has no captured start yet.
    echo_tof = (run == '0) ? index : run_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run       <= '0;
      run_start <= '0;
    end else if (clear) begin
      run       <= '0;
      run_start <= '0;
    end else if (sample) begin
      if (cmp_in) begin
        if (run == '0) run_start <= index;
        if (run != '1) run <= run + DEB_W'(1);
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/echo_tof_timer.sv
// Sonar echo time-of-flight timer: after a ping, blanks the ring-down, then
// listens for a debounced comparator echo or gives up at the timeout.
module echo_tof_timer
  import sonar_pkg::*;
#(
  parameter int CNT_W = TOF_CNT_W,
  parameter int DEB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cmp_in,
  input  logic             start,
  input  logic [15:0]      blank_len,
  input  logic [DEB_W-1:0] deb_len,
  input  logic [CNT_W-1:0] timeout,
  output logic             busy,
  output logic [CNT_W-1:0] tof,
  output logic             tof_valid,
  output logic             timeout_flag,
  output logic             irq
);

  localparam int CMP_W = (CNT_W > 16) ? CNT_W : 16;

  tof_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] echo_tof;
  logic             sample, echo, to_hit, blank_end;

  always_comb begin
    idx       = (&cnt) ? cnt : cnt + CNT_W'(1);
    blank_end = CMP_W'(idx) >= CMP_W'(blank_len);
    sample    = tick && !start && (state == ST_LISTEN);
    // An echo on the same tick beats the timeout.
    to_hit    = sample && !echo && (idx >= timeout);
  end

  echo_debounce #(
    .CNT_W(CNT_W),
    .DEB_W(DEB_W)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .sample   (sample),
    .cmp_in   (cmp_in),
    .index    (idx),
    .deb_len  (deb_len),
    .echo     (echo),
    .echo_tof (echo_tof)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (blank_len != '0) ? ST_BLANK : ST_LISTEN;
    end else begin
      case (state)
        ST_BLANK:  if (tick && blank_end) state_nxt = ST_LISTEN;
        ST_LISTEN: if (echo || to_hit)    state_nxt = ST_DONE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_BLANK) || (state == ST_LISTEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      tof          <= '0;
      tof_valid    <= 1'b0;
      timeout_flag <= 1'b0;
      irq          <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (start) begin
        cnt          <= '0;
        tof_valid    <= 1'b0;
        timeout_flag <= 1'b0;
      end else if (tick && busy) begin
        cnt <= idx;
        if (echo) begin
          tof       <= echo_tof;
          tof_valid <= 1'b1;
          irq       <= 1'b1;
        end else if (to_hit) begin
          tof          <= '1;
          timeout_flag <= 1'b1;
          tof_valid    <= 1'b1;
          irq          <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_tof_timer.sv
// Randomized bench for echo_tof_timer against a window-search reference model
// of the echo/timeout rules, plus directed cases for the corner behaviours.
module tb_echo_tof_timer;
  import sonar_pkg::*;

  localparam int CNT_W = 24;
  localparam int DEB_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic             cmp_in = 1'b0;
  logic             start = 1'b0;
  logic [15:0]      blank_len = '0;
  logic [DEB_W-1:0] deb_len = '0;
  logic [CNT_W-1:0] timeout = '0;
  logic             busy, tof_valid, timeout_flag, irq;
  logic [CNT_W-1:0] tof;

  int vectors = 0;
  int errors  = 0;
  bit pat [0:255];

  always #5 clk = ~clk;

  echo_tof_timer #(.CNT_W(CNT_W), .DEB_W(DEB_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .cmp_in       (cmp_in),
    .start        (start),
    .blank_len    (blank_len),
    .deb_len      (deb_len),
    .timeout      (timeout),
    .busy         (busy),
    .tof          (tof),
    .tof_valid    (tof_valid),
    .timeout_flag (timeout_flag),
    .irq          (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs held across the rising edge, outputs readable after return.
  task automatic step(input logic t, input logic c, input logic s);
    tick = t; cmp_in = c; start = s;
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; cmp_in = 1'($urandom_range(0, 1));
  endtask

  // Idle cycles between ticks with a noisy comparator; nothing may happen.
  task automatic gap();
    int g;
    g = $urandom_range(0, 2);
    repeat (g) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      check("gap_irq", irq, 0);
    end
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 256; i++) pat[i] = 1'b0;
  endtask

  // Reference: the echo is the first tick e after blanking whose deb-long
  // window ending at e is all high; listening ends at max(timeout, blank+1).
  task automatic model(input int blank, input int deb, input int to,
                       output int done_k, output int etof, output bit eflag);
    int d, t0, s;
    bit all;
    d      = (deb == 0) ? 1 : deb;
    t0     = (to > blank) ? to : blank + 1;
    done_k = t0;
    etof   = 32'h00FF_FFFF;
    eflag  = 1'b1;
    for (int e = blank + 1; e <= t0; e++) begin
      s   = e - d + 1;
      all = (s >= blank + 1);
      if (all) for (int j = s; j <= e; j++) if (!pat[j]) all = 1'b0;
      if (all) begin
        done_k = e; etof = s; eflag = 1'b0;
        break;
      end
    end
  endtask

  task automatic set_cfg(input int blank, input int deb, input int to);
    blank_len = 16'(blank);
    deb_len   = DEB_W'(deb);
    timeout   = CNT_W'(to);
  endtask

  // Start a measurement and apply n ticks that must not finish it.
  task automatic prefix(input int blank, input int deb, input int to, input int n);
    set_cfg(blank, deb, to);
    step(1'b0, 1'b0, 1'b1);
    check("pre_start_busy", busy, 1);
    for (int k = 1; k <= n; k++) begin
      gap();
      step(1'b1, pat[k], 1'b0);
      check("pre_irq", irq, 0);
      check("pre_busy", busy, 1);
    end
  endtask

  // Full measurement; start_tick puts a qualifying-looking sample on the start clock.
  task automatic run_meas(input int blank, input int deb, input int to,
                          input bit start_tick, output int got_tof);
    int done_k, etof;
    bit eflag;
    model(blank, deb, to, done_k, etof, eflag);
    set_cfg(blank, deb, to);
    step(start_tick, start_tick, 1'b1);
    check("start_busy", busy, 1);
    check("start_irq", irq, 0);
    check("start_valid", tof_valid, 0);
    check("start_toflag", timeout_flag, 0);
    for (int k = 1; k <= done_k; k++) begin
      gap();
      step(1'b1, pat[k], 1'b0);
      if (k < done_k) begin
        check("run_busy", busy, 1);
        check("run_irq", irq, 0);
        check("run_valid", tof_valid, 0);
      end else begin
        check("done_busy", busy, 0);
        check("done_irq", irq, 1);
        check("done_valid", tof_valid, 1);
        check("done_toflag", timeout_flag, 32'(eflag));
        check("done_tof", tof, etof);
      end
    end
    repeat (4) begin
      gap();
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check("hold_irq", irq, 0);
      check("hold_busy", busy, 0);
      check("hold_valid", tof_valid, 1);
      check("hold_tof", tof, etof);
    end
    got_tof = int'(tof);
  endtask

  initial begin
    int got, blank, deb, to, dens;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_tof", tof, 0);
    check("rst_valid", tof_valid, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check("idle_busy", busy, 0);
    check("idle_irq", irq, 0);

    // Echo onset at tick 10, debounced over two samples.
    clear_pat();
    for (int k = 10; k < 256; k++) pat[k] = 1'b1;
    run_meas(4, 2, 100, 1'b0, got);
    check("dir_tof_10", got, 10);

    // Single-sample glitch rejected, real echo at 20.
    clear_pat();
    pat[10] = 1'b1; pat[20] = 1'b1; pat[21] = 1'b1;
    run_meas(4, 2, 100, 1'b0, got);
    check("dir_glitch_tof", got, 20);

    // Ring-down hits during blanking only: timeout.
    clear_pat();
    for (int k = 1; k <= 4; k++) pat[k] = 1'b1;
    run_meas(4, 2, 100, 1'b0, got);
    check("dir_timeout_tof", got, 32'h00FF_FFFF);
    check("dir_timeout_flag", timeout_flag, 1);

    // deb_len 0 acts as 1; echo on the timeout tick wins.
    clear_pat();
    pat[50] = 1'b1;
    run_meas(4, 0, 50, 1'b0, got);
    check("dir_deb0_tof", got, 50);
    check("dir_deb0_flag", timeout_flag, 0);

    // Restart on tick 30 of a silent listen, echo at restarted tick 12.
    clear_pat();
    prefix(4, 2, 100, 29);
    clear_pat();
    pat[12] = 1'b1; pat[13] = 1'b1;
    run_meas(4, 2, 100, 1'b1, got);
    check("dir_restart_tof", got, 12);

    // Start coincides with the sample that would qualify: restart, no irq.
    clear_pat();
    pat[10] = 1'b1;
    prefix(4, 2, 100, 10);
    clear_pat();
    pat[30] = 1'b1; pat[31] = 1'b1;
    run_meas(4, 2, 100, 1'b1, got);
    check("dir_override_tof", got, 30);

    // Reset between edges while listening.
    clear_pat();
    prefix(4, 2, 100, 8);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_tof", tof, 0);
    check("arst_valid", tof_valid, 0);
    check("arst_toflag", timeout_flag, 0);
    check("arst_irq", irq, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      step(1'b1, 1'b1, 1'b0);
      check("post_rst_busy", busy, 0);
      check("post_rst_irq", irq, 0);
      check("post_rst_valid", tof_valid, 0);
    end

    // Randomized measurements, including timeout <= blank_len.
    repeat (24) begin
      blank = $urandom_range(0, 20);
      deb   = $urandom_range(0, 5);
      to    = $urandom_range(0, 120);
      dens  = $urandom_range(10, 75);
      clear_pat();
      for (int k = 1; k < 256; k++) pat[k] = ($urandom_range(0, 99) < dens);
      run_meas(blank, deb, to, 1'($urandom_range(0, 1)), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/echo_tof_timer.md
ECHO_TOF_TIMER -- requirements
Module: echo_tof_timer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 24, meaning the tick-counter and time-of-flight width in bits.
REQ-002 The block SHALL have parameter DEB_W, default 4, meaning the debounce-length width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 The block SHALL have port tick, input, 1, sample enable (PCM-rate strobe); one-clk pulse per sample.
REQ-006 The block SHALL have port cmp_in, input, 1, threshold-comparator output for the channel; sampled only on tick.
REQ-007 The block SHALL have port start, input, 1, one-clk pulse marking ping transmission.
REQ-008 The block SHALL have port blank_len, input, 16, number of ticks ignored after start (transmit ring-down).
REQ-009 The block SHALL have port deb_len, input, DEB_W, consecutive high samples required for an echo; 0 treated as 1.
REQ-010 The block SHALL have port timeout, input, CNT_W, tick index at which listening ends without an echo.
REQ-011 The block SHALL have port busy, output, 1, high in BLANK and LISTEN.
REQ-012 The block SHALL have port tof, output, CNT_W, measured tick index of echo onset.
REQ-013 The block SHALL have port tof_valid, output, 1, high in DONE.
REQ-014 The block SHALL have port timeout_flag, output, 1, high in DONE when no echo was found.
REQ-015 The block SHALL have port irq, output, 1, one-clk pulse on entry to DONE.

Function
REQ-016 The FSM SHALL have states IDLE, BLANK, LISTEN, DONE; the next-state decision SHALL be registered, so outputs change the clk after the causing event.
REQ-017 On start in any state, the block SHALL clear cnt, run, tof_valid and timeout_flag, then enter BLANK if blank_len>0, else LISTEN; start SHALL override every other event in the same clk, including a qualifying sample.
REQ-018 In BLANK/LISTEN, each tick SHALL increment cnt, saturating at all-ones; the sample index of a tick is the incremented value, so the first tick is index 1.
REQ-019 In BLANK, on the tick whose index equals blank_len, the block SHALL go to LISTEN; samples with index <= blank_len SHALL be ignored.
REQ-020 In LISTEN, on a tick with cmp_in=1, the block SHALL capture run_start=index if run=0, then increment run; on a tick with cmp_in=0 it SHALL set run=0.
REQ-021 The block SHALL declare an echo when run reaches max(deb_len,1); it SHALL then set tof=run_start, tof_valid=1, irq=1 for one clk, and enter DONE.
REQ-022 If no echo is declared and index >= timeout on a LISTEN tick, the block SHALL set tof=all-ones, timeout_flag=1, tof_valid=1, irq=1 for one clk, and enter DONE.
REQ-023 If an echo and a timeout occur on the same tick, the echo SHALL win.
REQ-024 If timeout <= blank_len, the timeout SHALL fire on the first LISTEN tick unless that tick itself declares an echo.
REQ-025 DONE SHALL hold tof, tof_valid and timeout_flag until the next start; ticks and cmp_in SHALL be ignored in IDLE and DONE.
REQ-026 The block SHALL ignore cmp_in changes between ticks.

Reset
REQ-027 rst SHALL take the FSM to IDLE immediately (asynchronously), with cnt=0, run=0, run_start=0, tof=0, tof_valid=0, timeout_flag=0, irq=0, busy=0.
REQ-028 Assertion of rst mid-measurement SHALL abort the measurement without raising irq; after deassertion, the block SHALL wait for start.

Structure
REQ-029 The shared package sonar_pkg SHALL hold the state enum (tof_state_t), TOF_CNT_W=24, and TOF_NO_ECHO (all-ones code).
REQ-030 Debounce logic (run counter, run_start capture, echo-qualified strobe) SHALL be one sub-module, echo_debounce; the FSM and counter SHALL stay in echo_tof_timer.

Verification
REQ-031 Test case: blank_len=4, deb_len=2, timeout=100, cmp_in high from tick 10 onward -> tof=10, tof_valid=1 one clk after tick 11, irq exactly one clk, timeout_flag=0.
REQ-032 Test case: cmp_in high only at tick 10, high again at ticks 20-21, deb_len=2 -> tof=20 (glitch rejected).
REQ-033 Test case: blank_len=4, cmp_in high ticks 1-4 then low, timeout=100 -> DONE at tick 100, timeout_flag=1, tof=0xFFFFFF.
REQ-034 Test case: deb_len=0, timeout=50, cmp_in high only at tick 50 -> tof=50, timeout_flag=0.
REQ-035 Test case: start reissued at tick 30 in LISTEN, then echo at restarted tick 12 -> tof=12, single irq; and start coincident with a qualifying sample -> restart, no irq.
REQ-036 Test case: rst asserted between clk edges during LISTEN -> busy=0 and all outputs 0 before the next edge; no irq follows.
